sram_rw_port_ctrl: RTL and testbench

//  Initiator for a single-port RW0_* synchronous SRAM macro (1-cycle read latency, no output reg).

---
 rtl/sram_port_pkg.sv | 11 +
 rtl/sram_rw_port_ctrl_if.sv | 27 ++
 rtl/sram_rw_port_ctrl_resp_fifo2.sv | 56 +++++
 rtl/sram_rw_port_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_pkg.sv
// rtl/sram_port_pkg.sv - shared types and constants for the SRAM RW port controller
package sram_port_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RESP_DEPTH = 2;

endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// rtl/sram_rw_port_ctrl_if.sv - request/response stream bundle between client logic and the SRAM port controller
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_rw_port_ctrl_resp_fifo2.sv
// rtl/sram_rw_port_ctrl_resp_fifo2.sv - two-entry read-response FIFO; push and pop may coincide when full
module resp_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// rtl/sram_rw_port_ctrl.sv - RW0_* single-port SRAM initiator with post-reset clear and credited read returns
module sram_rw_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int                ADDR_W         = 10,
  parameter int                DATA_W         = 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  sram_rw_port_ctrl_if.slave  bus,
  output logic                init_done,
  output logic                RW0_clk,
  output logic                RW0_en,
  output logic                RW0_wmode,
  output logic                RW0_wmask,
  output logic [ADDR_W-1:0]   RW0_addr,
  output logic [DATA_W-1:0]   RW0_wdata,
  input  logic [DATA_W-1:0]   RW0_rdata
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              init_done_q, init_done_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [2:0]        credit_sum;
  logic              req_ready;
  logic              fire;
  logic              clearing;

  assign RW0_clk = clock;

  // Gating with reset_n keeps the macro idle while reset is held, even though the state resets to CLEAR.
  assign clearing   = reset_n && (state_q == ST_CLEAR);
  assign credit_sum = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign req_ready  = reset_n && (state_q == ST_RUN) && (credit_sum < 3'(RESP_DEPTH));
  assign fire       = bus.req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  assign inflight_d = fire && !bus.req_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      clr_addr_q  <= '0;
      init_done_q <= !CLEAR_ON_RESET;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
      inflight_q  <= inflight_d;
    end
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_wmask = 1'b0;
    RW0_addr  = bus.req_addr;
    RW0_wdata = bus.req_wdata;
    if (clearing) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_wmask = 1'b1;
      RW0_addr  = clr_addr_q;
      RW0_wdata = CLEAR_VALUE;
    end else if (fire) begin
      RW0_en    = 1'b1;
      RW0_wmode = bus.req_write;
      RW0_wmask = bus.req_write && bus.req_wmask;
    end
  end

  // Returning data bypasses an empty FIFO; it is only stored when the consumer stalls or older data waits.
  assign fifo_empty = (fifo_count == 2'd0);
  assign fifo_pop   = !fifo_empty && bus.resp_ready;
  assign fifo_push  = inflight_q && !(fifo_empty && bus.resp_ready);

  resp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (RW0_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = inflight_q || !fifo_empty;
  assign bus.resp_rdata = fifo_empty ? RW0_rdata : fifo_head;
  assign init_done      = init_done_q;

  a_credit_bound : assert property (@(posedge clock) disable iff (!reset_n)
    credit_sum <= 3'(RESP_DEPTH));

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb/tb_sram_rw_port_ctrl.sv - directed and random-stress bench for sram_rw_port_ctrl with a behavioural SRAM
module tb_sram_rw_port_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       init_done;
  logic       RW0_clk, RW0_en, RW0_wmode, RW0_wmask;
  logic [3:0] RW0_addr;
  logic [7:0] RW0_wdata;
  logic [7:0] RW0_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] sram [16] = '{default: 8'hEE};

  always #5 clock = ~clock;

  sram_rw_port_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sram_rw_port_ctrl #(
    .ADDR_W         (4),
    .DATA_W         (8),
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (8'h00)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done),
    .RW0_clk   (RW0_clk),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wmask (RW0_wmask),
    .RW0_addr  (RW0_addr),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  // Read data is only meaningful the cycle after a read; garbage otherwise.
  always @(posedge clock) begin
    if (RW0_en && RW0_wmode) begin
      if (RW0_wmask) sram[RW0_addr] <= RW0_wdata;
      RW0_rdata <= 8'($urandom);
    end else if (RW0_en) begin
      RW0_rdata <= sram[RW0_addr];
    end else begin
      RW0_rdata <= 8'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic m, input logic rr);
    @(negedge clock);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_wmask  = m;
    bus.resp_ready = rr;
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    check_eq(tag, 32'(n), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    int         outstanding;
    logic       v, w, m, rr, exp_ready, exp_rvalid;
    logic [3:0] a;
    logic [7:0] d;

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = 1'b0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_rw0_strobes", {RW0_en, RW0_wmode, RW0_wmask}, 3'b000);

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check_eq("clr_strobes", {RW0_en, RW0_wmode, RW0_wmask}, 3'b111);
      check_eq("clr_addr", RW0_addr, i);
      check_eq("clr_wdata", RW0_wdata, 8'h00);
      check_eq("clr_req_ready", bus.req_ready, 0);
      check_eq("clr_init_done", init_done, 0);
      @(negedge clock);
      #1;
    end
    check_eq("init_done_rise", init_done, 1);
    check_eq("run_req_ready", bus.req_ready, 1);
    check_eq("run_idle_en", RW0_en, 0);
    for (int i = 0; i < 16; i++) check_eq("clr_array", sram[i], 8'h00);

    // Write then read back with consumer ready
    drive(1, 1, 4'd3, 8'h5A, 1, 1);
    check_eq("wr_ready", bus.req_ready, 1);
    check_eq("wr_strobes", {RW0_en, RW0_wmode, RW0_wmask}, 3'b111);
    check_eq("wr_addr", RW0_addr, 4'd3);
    check_eq("wr_wdata", RW0_wdata, 8'h5A);
    drive(1, 0, 4'd3, 8'h00, 0, 1);
    check_eq("rd_strobes", {RW0_en, RW0_wmode}, 2'b10);
    check_eq("rd_resp_valid_early", bus.resp_valid, 0);
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("rd_resp_valid", bus.resp_valid, 1);
    check_eq("rd_rdata", bus.resp_rdata, 8'h5A);
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("rd_resp_gone", bus.resp_valid, 0);

    // Back-to-back reads against a stalled consumer
    drive(1, 1, 4'd1, 8'h11, 1, 1);
    drive(1, 1, 4'd2, 8'h22, 1, 1);
    drive(1, 0, 4'd1, 8'h00, 0, 0);
    check_eq("b2b_c0_ready", bus.req_ready, 1);
    drive(1, 0, 4'd2, 8'h00, 0, 0);
    check_eq("b2b_c1_ready", bus.req_ready, 1);
    check_eq("b2b_c1_rdata", bus.resp_rdata, 8'h11);
    drive(1, 0, 4'd3, 8'h00, 0, 0);
    check_eq("b2b_c2_ready", bus.req_ready, 0);
    check_eq("b2b_c2_en", RW0_en, 0);
    check_eq("b2b_c2_rdata", bus.resp_rdata, 8'h11);
    drive(1, 0, 4'd3, 8'h00, 0, 0);
    check_eq("b2b_c3_ready", bus.req_ready, 0);
    check_eq("b2b_c3_rdata", bus.resp_rdata, 8'h11);
    drive(1, 0, 4'd3, 8'h00, 0, 1);
    check_eq("b2b_c4_ready", bus.req_ready, 0);
    check_eq("b2b_c4_rdata", bus.resp_rdata, 8'h11);
    drive(1, 0, 4'd3, 8'h00, 0, 1);
    check_eq("b2b_c5_ready", bus.req_ready, 1);
    check_eq("b2b_c5_rdata", bus.resp_rdata, 8'h22);
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("b2b_c6_valid", bus.resp_valid, 1);
    check_eq("b2b_c6_rdata", bus.resp_rdata, 8'h5A);
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("b2b_c7_valid", bus.resp_valid, 0);
    check_eq("b2b_c7_ready", bus.req_ready, 1);

    // Masked-off write leaves the cleared word intact
    drive(1, 1, 4'd7, 8'hFF, 0, 1);
    check_eq("nomask_strobes", {RW0_en, RW0_wmode, RW0_wmask}, 3'b110);
    drive(1, 0, 4'd7, 8'h00, 0, 1);
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("nomask_valid", bus.resp_valid, 1);
    check_eq("nomask_rdata", bus.resp_rdata, 8'h00);

    // Reset right after a read fires
    drive(1, 0, 4'd3, 8'h00, 0, 0);
    check_eq("mid_rst_fire", bus.req_ready, 1);
    @(negedge clock);
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check_eq("mid_rst_valid", bus.resp_valid, 0);
    check_eq("mid_rst_en", RW0_en, 0);
    check_eq("mid_rst_init", init_done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("restart_addr", RW0_addr, 4'd0);
    check_eq("restart_strobes", {RW0_en, RW0_wmode, RW0_wmask}, 3'b111);
    check_eq("restart_valid", bus.resp_valid, 0);
    wait_init("restart_clear_len");
    check_eq("restart_ready", bus.req_ready, 1);

    // Random stress against a credit/ordering model
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    outstanding = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 2) == 0);
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      m  = 1'($urandom_range(0, 3) != 0);
      rr = 1'($urandom_range(0, 2) != 0);
      drive(v, w, a, d, m, rr);
      exp_ready  = (outstanding < 2);
      exp_rvalid = (outstanding > 0);
      check_eq("stress_ready", bus.req_ready, exp_ready);
      check_eq("stress_rvalid", bus.resp_valid, exp_rvalid);
      if (exp_rvalid && rr) begin
        check_eq("stress_rdata", bus.resp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
        outstanding--;
      end
      if (v && exp_ready) begin
        if (w) begin
          if (m) ref_mem[a] = d;
        end else begin
          exp_q.push_back(ref_mem[a]);
          outstanding++;
        end
      end
    end
    for (int k = 0; k < 4 && outstanding > 0; k++) begin
      drive(0, 0, 4'd0, 8'h00, 0, 1);
      check_eq("drain_rvalid", bus.resp_valid, 1);
      check_eq("drain_rdata", bus.resp_rdata, exp_q[0]);
      void'(exp_q.pop_front());
      outstanding--;
    end
    drive(0, 0, 4'd0, 8'h00, 0, 1);
    check_eq("drain_empty", bus.resp_valid, 0);
    check_eq("drain_ready", bus.req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
